clause_loader: RTL and testbench

CLAUSE_LOADER -- requirements
Module: clause_loader

---
 rtl/clause_pkg.sv | 20 ++
 rtl/clause_loader.sv | 125 ++++++++++++
 tb/tb_clause_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_pkg.sv
// clause_pkg
// Shared definitions for the clause loading path: the default clause word
// width, the default width of the loaded-word counter, and the loader state
// encoding. The loader and the downstream clause shift-register stage both
// import this package.
package clause_pkg;

  // Default clause word width. It matches the downstream shift register.
  localparam int N_DEFAULT = 8;

  // Default width of the count of fully shifted words.
  localparam int C_DEFAULT = 8;

  // IDLE waits for a word. SHIFT serializes the buffered word onto sin.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/clause_loader.sv
// clause_loader
// Accepts parallel clause words over a valid/ready handshake. Each word is
// serialized LSB first into a downstream right-shifting register, one bit
// per load pulse. After N load pulses, that register holds the original word.
// A word can be accepted during the last-bit cycle of the previous word, so
// back-to-back words stream with no gap.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous reset, active low
//   in_valid  upstream has a word on in_data
//   in_data   parallel clause word (N bits)
//   in_ready  word is taken this cycle if in_valid is also high
//   hold      downstream stall; freezes the shifter while high
//   load      shift enable to the downstream register
//   sin       serial bit to the downstream register, valid with load
//   busy      high while a word is being serialized
//   done      one-cycle pulse after the last bit of a word has shifted
//   count     number of fully shifted words, modulo 2^C
module clause_loader
  import clause_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int C = C_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         hold,
  output logic         load,
  output logic         sin,
  output logic         busy,
  output logic         done,
  output logic [C-1:0] count
);

  // Width of the bit counter. It is kept at one bit or more for N = 1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q, state_d;
  logic [N-1:0]   shiftBuf_q, shiftBuf_d;
  logic [CW-1:0]  bitCnt_q, bitCnt_d;
  logic           done_q, done_d;
  logic [C-1:0]   count_q, count_d;
  logic           lastBit;
  logic           accept;

  // The last-bit cycle needs the bit counter at its top value. It also needs
  // hold low, so a stalled final bit does not open the input early.
  assign lastBit = (state_q == SHIFT) && !hold && (bitCnt_q == CW'(N - 1));

  // in_ready is gated by reset so the handshake stays closed during reset.
  assign accept  = in_valid && in_ready;

  // State register. Reset discards any partial word without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shiftBuf_q <= '0;
      bitCnt_q   <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shiftBuf_q <= shiftBuf_d;
      bitCnt_q   <= bitCnt_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic.
  // In the last-bit cycle, the finishing word raises done and bumps the
  // count. In the same cycle, a newly accepted word reloads the buffer, so
  // shifting continues without a bubble.
  always_comb begin
    state_d    = state_q;
    shiftBuf_d = shiftBuf_q;
    bitCnt_d   = bitCnt_q;
    done_d     = 1'b0;
    count_d    = count_q;
    if (state_q == IDLE) begin
      if (accept) begin
        shiftBuf_d = in_data;
        bitCnt_d   = '0;
        state_d    = SHIFT;
      end
    end else if (!hold) begin
      shiftBuf_d = shiftBuf_q >> 1;
      bitCnt_d   = bitCnt_q + CW'(1);
      if (lastBit) begin
        done_d  = 1'b1;
        count_d = count_q + C'(1);
        if (accept) begin
          shiftBuf_d = in_data;
          bitCnt_d   = '0;
          state_d    = SHIFT;
        end else begin
          bitCnt_d   = '0;
          state_d    = IDLE;
        end
      end
    end
  end

  // Output logic.
  // sin follows the buffer LSB throughout SHIFT, so it stays stable under
  // hold. In IDLE, sin is forced to 0.
  always_comb begin
    load     = 1'b0;
    sin      = 1'b0;
    busy     = 1'b0;
    in_ready = reset && ((state_q == IDLE) || lastBit);
    done     = done_q;
    count    = count_q;
    if (state_q == SHIFT) begin
      busy = 1'b1;
      sin  = shiftBuf_q[0];
      load = !hold;
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// tb_clause_loader
// Directed bench for clause_loader with N = 8 and C = 8. A behavioural
// right-shifting clause register sits downstream, fed by load and sin.
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge.
module tb_clause_loader;
  import clause_pkg::*;

  localparam int N = N_DEFAULT;
  localparam int C = C_DEFAULT;

  logic         clk;
  logic         reset;
  logic         inValid;
  logic [N-1:0] inData;
  logic         hold;
  logic         inReady;
  logic         load;
  logic         sin;
  logic         busy;
  logic         done;
  logic [C-1:0] count;
  logic [N-1:0] q;

  int           vecs;
  int           miss;
  logic [C-1:0] expCount;

  clause_loader #(.N(N), .C(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (inValid),
    .in_data  (inData),
    .in_ready (inReady),
    .hold     (hold),
    .load     (load),
    .sin      (sin),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  // Downstream clause shift register: MSB serial input, shifts right.
  always_ff @(posedge clk) begin
    if (load) q <= {sin, q[N-1:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle;
    @(negedge clk);
  endtask

  // Control vector order in every check: {load, sin, busy, in_ready, done}.
  task automatic test_reset;
    reset = 1'b0; inValid = 1'b0; inData = '0; hold = 1'b0; expCount = '0;
    repeat (2) nextCycle;
    #1;
    vecs++; if ({load, sin, busy, inReady, done} !== 5'b00000) begin miss++; $display("[TB] FAIL reset_ctl: got %b expected %b", {load, sin, busy, inReady, done}, 5'b00000); end
    vecs++; if (count !== 8'h00) begin miss++; $display("[TB] FAIL reset_count: got %h expected %h", count, 8'h00); end
    nextCycle;
    reset = 1'b1;
    #1;
    vecs++; if ({load, busy, inReady, done} !== 4'b0010) begin miss++; $display("[TB] FAIL release_ctl: got %b expected %b", {load, busy, inReady, done}, 4'b0010); end
    nextCycle;
  endtask

  task automatic test_single;
    logic [N-1:0] w;
    w = 8'hA5;
    inValid = 1'b1; inData = w;
    #1;
    vecs++; if (inReady !== 1'b1) begin miss++; $display("[TB] FAIL single_ready: got %b expected 1", inReady); end
    nextCycle;
    inValid = 1'b0; inData = '0;
    for (int i = 0; i < N; i++) begin
      #1;
      vecs++; if ({load, sin, busy, inReady, done} !== {1'b1, w[i], 1'b1, (i == N-1), 1'b0}) begin miss++; $display("[TB] FAIL single_bit%0d: got %b expected %b", i, {load, sin, busy, inReady, done}, {1'b1, w[i], 1'b1, (i == N-1), 1'b0}); end
      nextCycle;
    end
    expCount = expCount + 8'd1;
    #1;
    vecs++; if ({load, sin, busy, inReady, done} !== 5'b00011) begin miss++; $display("[TB] FAIL single_end: got %b expected %b", {load, sin, busy, inReady, done}, 5'b00011); end
    vecs++; if (q !== w) begin miss++; $display("[TB] FAIL single_q: got %h expected %h", q, w); end
    vecs++; if (count !== expCount) begin miss++; $display("[TB] FAIL single_count: got %h expected %h", count, expCount); end
    nextCycle;
    #1;
    vecs++; if (done !== 1'b0) begin miss++; $display("[TB] FAIL single_done_clear: got %b expected 0", done); end
    nextCycle;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] w1, w2;
    w1 = 8'h01; w2 = 8'hFF;
    inValid = 1'b1; inData = w1;
    nextCycle;
    inData = w2;
    for (int i = 0; i < N; i++) begin
      #1;
      vecs++; if ({load, sin, busy, inReady, done} !== {1'b1, w1[i], 1'b1, (i == N-1), 1'b0}) begin miss++; $display("[TB] FAIL b2b_w1_bit%0d: got %b expected %b", i, {load, sin, busy, inReady, done}, {1'b1, w1[i], 1'b1, (i == N-1), 1'b0}); end
      nextCycle;
    end
    inValid = 1'b0; inData = '0;
    for (int i = 0; i < N; i++) begin
      #1;
      vecs++; if ({load, sin, busy, inReady, done} !== {1'b1, w2[i], 1'b1, (i == N-1), (i == 0)}) begin miss++; $display("[TB] FAIL b2b_w2_bit%0d: got %b expected %b", i, {load, sin, busy, inReady, done}, {1'b1, w2[i], 1'b1, (i == N-1), (i == 0)}); end
      nextCycle;
    end
    expCount = expCount + 8'd2;
    #1;
    vecs++; if ({load, busy, done} !== 3'b001) begin miss++; $display("[TB] FAIL b2b_end: got %b expected %b", {load, busy, done}, 3'b001); end
    vecs++; if (q !== w2) begin miss++; $display("[TB] FAIL b2b_q: got %h expected %h", q, w2); end
    vecs++; if (count !== expCount) begin miss++; $display("[TB] FAIL b2b_count: got %h expected %h", count, expCount); end
    nextCycle;
  endtask

  task automatic test_hold;
    logic [N-1:0] w;
    int bitIdx;
    w = 8'h3C;
    inValid = 1'b1; inData = w;
    nextCycle;
    inValid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      hold   = (c >= 5 && c < 8);
      bitIdx = (c < 5) ? c : ((c < 8) ? 5 : c - 3);
      #1;
      vecs++; if ({load, sin, busy, inReady, done} !== {!hold, w[bitIdx], 1'b1, (c == 10), 1'b0}) begin miss++; $display("[TB] FAIL hold_cyc%0d: got %b expected %b", c, {load, sin, busy, inReady, done}, {!hold, w[bitIdx], 1'b1, (c == 10), 1'b0}); end
      nextCycle;
    end
    hold = 1'b0;
    expCount = expCount + 8'd1;
    #1;
    vecs++; if (q !== w) begin miss++; $display("[TB] FAIL hold_q: got %h expected %h", q, w); end
    vecs++; if ({done, count} !== {1'b1, expCount}) begin miss++; $display("[TB] FAIL hold_done_count: got %h expected %h", {done, count}, {1'b1, expCount}); end
    nextCycle;
  endtask

  task automatic test_hold_last;
    logic [N-1:0] w1, w2;
    w1 = 8'h5A; w2 = 8'hC3;
    inValid = 1'b1; inData = w1;
    nextCycle;
    inValid = 1'b0;
    for (int i = 0; i < N-1; i++) begin
      #1;
      vecs++; if ({load, sin} !== {1'b1, w1[i]}) begin miss++; $display("[TB] FAIL hlast_bit%0d: got %b expected %b", i, {load, sin}, {1'b1, w1[i]}); end
      nextCycle;
    end
    hold = 1'b1; inValid = 1'b1; inData = w2;
    for (int c = 0; c < 2; c++) begin
      #1;
      vecs++; if ({load, sin, busy, inReady} !== {1'b0, w1[N-1], 1'b1, 1'b0}) begin miss++; $display("[TB] FAIL hlast_stall%0d: got %b expected %b", c, {load, sin, busy, inReady}, {1'b0, w1[N-1], 1'b1, 1'b0}); end
      nextCycle;
    end
    hold = 1'b0;
    #1;
    vecs++; if ({load, sin, inReady} !== {1'b1, w1[N-1], 1'b1}) begin miss++; $display("[TB] FAIL hlast_release: got %b expected %b", {load, sin, inReady}, {1'b1, w1[N-1], 1'b1}); end
    nextCycle;
    inValid = 1'b0; inData = '0;
    for (int i = 0; i < N; i++) begin
      #1;
      vecs++; if ({load, sin, done} !== {1'b1, w2[i], (i == 0)}) begin miss++; $display("[TB] FAIL hlast_w2_bit%0d: got %b expected %b", i, {load, sin, done}, {1'b1, w2[i], (i == 0)}); end
      nextCycle;
    end
    expCount = expCount + 8'd2;
    #1;
    vecs++; if (q !== w2) begin miss++; $display("[TB] FAIL hlast_q: got %h expected %h", q, w2); end
    vecs++; if ({done, count} !== {1'b1, expCount}) begin miss++; $display("[TB] FAIL hlast_done_count: got %h expected %h", {done, count}, {1'b1, expCount}); end
    nextCycle;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] w1, w2;
    w1 = 8'h77; w2 = 8'h12;
    inValid = 1'b1; inData = w1;
    nextCycle;
    inValid = 1'b0;
    repeat (6) nextCycle;
    reset = 1'b0;
    #1;
    vecs++; if ({load, sin, busy, inReady, done} !== 5'b00000) begin miss++; $display("[TB] FAIL rmid_ctl: got %b expected %b", {load, sin, busy, inReady, done}, 5'b00000); end
    vecs++; if (count !== 8'h00) begin miss++; $display("[TB] FAIL rmid_count: got %h expected %h", count, 8'h00); end
    expCount = '0;
    nextCycle;
    reset = 1'b1;
    #1;
    vecs++; if ({busy, inReady, done} !== 3'b010) begin miss++; $display("[TB] FAIL rmid_release: got %b expected %b", {busy, inReady, done}, 3'b010); end
    inValid = 1'b1; inData = w2;
    nextCycle;
    inValid = 1'b0;
    repeat (N) nextCycle;
    expCount = expCount + 8'd1;
    #1;
    vecs++; if (q !== w2) begin miss++; $display("[TB] FAIL rmid_q: got %h expected %h", q, w2); end
    vecs++; if ({done, count} !== {1'b1, expCount}) begin miss++; $display("[TB] FAIL rmid_done_count: got %h expected %h", {done, count}, {1'b1, expCount}); end
    nextCycle;
  endtask

  // 256 words streamed back to back. in_valid stays high between
  // acceptances, so the word on in_data changes every cycle and the
  // not-ready cycles must ignore it. Word k is accepted at cycle 8k and its
  // done pulse appears at cycle 8k+9.
  task automatic test_wrap;
    reset = 1'b0;
    nextCycle;
    reset = 1'b1;
    for (int cyc = 0; cyc <= 2049; cyc++) begin
      inValid = (cyc <= 2040);
      inData  = 8'(cyc);
      #1;
      if (cyc <= 2048) begin
        vecs++; if (inReady !== (cyc % 8 == 0)) begin miss++; $display("[TB] FAIL wrap_ready_cyc%0d: got %b expected %b", cyc, inReady, (cyc % 8 == 0)); end
      end
      vecs++; if (done !== (cyc >= 9 && cyc % 8 == 1)) begin miss++; $display("[TB] FAIL wrap_done_cyc%0d: got %b expected %b", cyc, done, (cyc >= 9 && cyc % 8 == 1)); end
      if (cyc >= 9 && cyc % 8 == 1) begin
        vecs++; if (count !== 8'((cyc - 1) / 8)) begin miss++; $display("[TB] FAIL wrap_count_cyc%0d: got %h expected %h", cyc, count, 8'((cyc - 1) / 8)); end
        vecs++; if (q !== 8'(cyc - 9)) begin miss++; $display("[TB] FAIL wrap_q_cyc%0d: got %h expected %h", cyc, q, 8'(cyc - 9)); end
      end
      nextCycle;
    end
    inValid = 1'b0;
    #1;
    vecs++; if ({busy, count} !== 9'h000) begin miss++; $display("[TB] FAIL wrap_final: got %h expected %h", {busy, count}, 9'h000); end
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_hold;
    test_hold_last;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
